// File: rtl/control_pkg.sv
// Shared definitions for the opcode decoder and the control pipeline.
// The bundle widths, control bit positions and bubble constants live here.
package control_pkg;

    localparam int WB_W   = 2;
    localparam int MEM_W  = 3;
    localparam int CALC_W = 4;

    localparam int REG_WRITE_BIT   = 0;
    localparam int MEM_TO_REG_BIT  = 1;
    localparam int MEM_READ_BIT    = 0;
    localparam int MEM_WRITE_BIT   = 1;
    localparam int BYTE_ACCESS_BIT = 2;

    typedef struct packed {
        logic              valid;
        logic [WB_W-1:0]   wb;
        logic [MEM_W-1:0]  mem;
        logic [CALC_W-1:0] calc;
    } ex_stage_t;

    typedef struct packed {
        logic             valid;
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
    } mem_stage_t;

    typedef struct packed {
        logic            valid;
        logic [WB_W-1:0] wb;
    } wb_stage_t;

    // A bubble carries no valid bit and no control bits.
    localparam ex_stage_t  EX_BUBBLE  = '0;
    localparam mem_stage_t MEM_BUBBLE = '0;
    localparam wb_stage_t  WB_BUBBLE  = '0;

    function automatic mem_stage_t ex_to_mem(input ex_stage_t ex);
        mem_stage_t result;
        result.valid = ex.valid;
        result.wb    = ex.wb;
        result.mem   = ex.mem;
        return result;
    endfunction

    function automatic wb_stage_t mem_to_wb(input mem_stage_t mem);
        wb_stage_t result;
        result.valid = mem.valid;
        result.wb    = mem.wb;
        return result;
    endfunction

endpackage

// File: rtl/control_pipeline_sat_counter.sv
// Saturating up-counter used to count retired instructions.
// The count holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (inc && (count != MAX_COUNT)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/control_pipeline.sv
// Carries decoded control bundles from decode through execute, memory-access
// and write-back, with stall bubbles, flush squashing and a retired count.
module control_pipeline
    import control_pkg::*;
#(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [WB_W-1:0]        writeBackControl,
    input  logic [MEM_W-1:0]       memAccessControl,
    input  logic [CALC_W-1:0]      calculationControl,
    input  logic                   inValid,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   inReady,
    output logic [CALC_W-1:0]      exCalculationControl,
    output logic                   exValid,
    output logic [MEM_W-1:0]       memControl,
    output logic                   memValid,
    output logic [WB_W-1:0]        wbControl,
    output logic                   wbValid,
    output logic                   loadUseHazard,
    output logic [COUNT_WIDTH-1:0] retiredCount
);

    ex_stage_t  ex_q;
    mem_stage_t mem_q;
    wb_stage_t  wb_q;
    ex_stage_t  ex_next;

    // An empty decode slot enters as an all-zero bubble so control bits never leak.
    always_comb begin
        ex_next = EX_BUBBLE;
        if (inValid) begin
            ex_next.valid = 1'b1;
            ex_next.wb    = writeBackControl;
            ex_next.mem   = memAccessControl;
            ex_next.calc  = calculationControl;
        end
    end

    // Write-back always advances so the instruction in memory-access completes;
    // flush takes priority over stall for the two younger stages.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ex_q  <= EX_BUBBLE;
            mem_q <= MEM_BUBBLE;
            wb_q  <= WB_BUBBLE;
        end else begin
            wb_q <= mem_to_wb(mem_q);
            if (flush) begin
                ex_q  <= EX_BUBBLE;
                mem_q <= MEM_BUBBLE;
            end else if (stall) begin
                mem_q <= MEM_BUBBLE;
            end else begin
                ex_q  <= ex_next;
                mem_q <= ex_to_mem(ex_q);
            end
        end
    end

    assign inReady              = !stall && !flush;
    assign exCalculationControl = ex_q.calc;
    assign exValid              = ex_q.valid;
    assign memControl           = mem_q.mem;
    assign memValid             = mem_q.valid;
    assign wbControl            = wb_q.wb;
    assign wbValid              = wb_q.valid;
    assign loadUseHazard        = ex_q.valid && ex_q.mem[MEM_READ_BIT];

    sat_counter #(
        .WIDTH(COUNT_WIDTH)
    ) retired_counter (
        .clk   (clk),
        .resetN(resetN),
        .inc   (wb_q.valid),
        .count (retiredCount)
    );

endmodule
